stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear controller for the stopwatch timebase. It owns a 1 ms tick prescaler and the elapsed-time counters (minutes, seconds, milliseconds), and sequences them from one-cycle button strobes. It also selects live or lap-frozen time for the 7-segment adapter. It sits between the button debouncers and the display adapter, in the same `i_sclk` domain.

---
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear stopwatch controller with 1 ms prescaler
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int MIN_MAX  = 99,
    parameter int PRE_W    = 17
) (
    input  logic       i_sclk,
    input  logic       i_reset,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    output logic [9:0] o_ms,
    output logic [5:0] o_sec,
    output logic [6:0] o_min,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_tick,
    output logic       o_wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PRE_W-1:0] r_pre, w_pre_nxt;
    logic [9:0]       r_ms, w_ms_nxt, r_lap_ms, w_lap_ms_nxt;
    logic [5:0]       r_sec, w_sec_nxt, r_lap_sec, w_lap_sec_nxt;
    logic [6:0]       r_min, w_min_nxt, r_lap_min, w_lap_min_nxt;
    logic             r_tick, r_wrap;
    logic             w_counting, w_tick, w_wrap;

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_ms      <= '0;
            r_sec     <= '0;
            r_min     <= '0;
            r_lap_ms  <= '0;
            r_lap_sec <= '0;
            r_lap_min <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_ms      <= w_ms_nxt;
            r_sec     <= w_sec_nxt;
            r_min     <= w_min_nxt;
            r_lap_ms  <= w_lap_ms_nxt;
            r_lap_sec <= w_lap_sec_nxt;
            r_lap_min <= w_lap_min_nxt;
            r_tick    <= w_tick;
            r_wrap    <= w_wrap;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lap_ms_nxt  = r_lap_ms;
        w_lap_sec_nxt = r_lap_sec;
        w_lap_min_nxt = r_lap_min;
        w_ms_nxt      = r_ms;
        w_sec_nxt     = r_sec;
        w_min_nxt     = r_min;
        w_wrap        = 1'b0;
        w_counting    = (r_state == S_RUN) || (r_state == S_LAP);
        w_tick        = w_counting && (r_pre == PRE_W'(TICK_DIV - 1));
        w_pre_nxt     = r_pre;
        if (w_counting)
            w_pre_nxt = w_tick ? '0 : r_pre + PRE_W'(1);

        // The increment is computed first so a tick on a leaving edge still lands.
        if (w_tick) begin
            if (r_ms == 10'd999) begin
                w_ms_nxt = '0;
                if (r_sec == 6'd59) begin
                    w_sec_nxt = '0;
                    if (r_min == 7'(MIN_MAX)) begin
                        w_min_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_min_nxt = r_min + 7'd1;
                    end
                end else begin
                    w_sec_nxt = r_sec + 6'd1;
                end
            end else begin
                w_ms_nxt = r_ms + 10'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (i_start_stop) begin
                    w_state_nxt = S_RUN;
                    w_pre_nxt   = '0;
                end
            end
            S_RUN: begin
                if (i_start_stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (i_lap) begin
                    w_state_nxt   = S_LAP;
                    w_lap_ms_nxt  = r_ms;
                    w_lap_sec_nxt = r_sec;
                    w_lap_min_nxt = r_min;
                end
            end
            S_LAP: begin
                if (i_start_stop)
                    w_state_nxt = S_PAUSE;
                else if (i_lap)
                    w_state_nxt = S_RUN;
            end
            S_PAUSE: begin
                if (i_clear) begin
                    w_state_nxt   = S_IDLE;
                    w_pre_nxt     = '0;
                    w_ms_nxt      = '0;
                    w_sec_nxt     = '0;
                    w_min_nxt     = '0;
                    w_lap_ms_nxt  = '0;
                    w_lap_sec_nxt = '0;
                    w_lap_min_nxt = '0;
                end else if (i_start_stop) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_ms         = (r_state == S_LAP) ? r_lap_ms  : r_ms;
    assign o_sec        = (r_state == S_LAP) ? r_lap_sec : r_sec;
    assign o_min        = (r_state == S_LAP) ? r_lap_min : r_min;
    assign o_running    = (r_state == S_RUN) || (r_state == S_LAP);
    assign o_lap_active = (r_state == S_LAP);
    assign o_tick       = r_tick;
    assign o_wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl (TICK_DIV=4, MIN_MAX=1)
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start_stop = 1'b0;
    logic       i_lap = 1'b0;
    logic       i_clear = 1'b0;
    logic [9:0] o_ms;
    logic [5:0] o_sec;
    logic [6:0] o_min;
    logic       o_running, o_lap_active, o_tick, o_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] mn;
        logic [5:0] sc;
        logic [9:0] ms;
        logic       wr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(4), .MIN_MAX(1), .PRE_W(3)) dut (
        .i_sclk       (clk),
        .i_reset      (i_reset),
        .i_start_stop (i_start_stop),
        .i_lap        (i_lap),
        .i_clear      (i_clear),
        .o_ms         (o_ms),
        .o_sec        (o_sec),
        .o_min        (o_min),
        .o_running    (o_running),
        .o_lap_active (o_lap_active),
        .o_tick       (o_tick),
        .o_wrap       (o_wrap)
    );

    // Every o_tick pulse must match the next expected displayed time and wrap flag.
    always @(negedge clk) begin
        if (o_tick === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_tick: got %0d:%0d.%0d wrap=%0b, none expected",
                         o_min, o_sec, o_ms, o_wrap);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({o_min, o_sec, o_ms, o_wrap} !== e) begin
                    errors++;
                    $display("FAIL sb_tick: got %0d:%0d.%0d wrap=%0b, want %0d:%0d.%0d wrap=%0b",
                             o_min, o_sec, o_ms, o_wrap, e.mn, e.sc, e.ms, e.wr);
                end
            end
        end
    end

    task automatic clk_step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int mn, input int sc, input int ms, input bit wr);
        exp_q.push_back({7'(mn), 6'(sc), 10'(ms), wr});
    endtask

    task automatic strobe(input bit ss, input bit lp, input bit clr);
        i_start_stop = ss;
        i_lap        = lp;
        i_clear      = clr;
        clk_step;
        i_start_stop = 1'b0;
        i_lap        = 1'b0;
        i_clear      = 1'b0;
    endtask

    task automatic wait_tick(input int bound);
        bit found = 1'b0;
        for (int n = 0; n < bound && !found; n++) begin
            clk_step;
            if (o_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_tick: no o_tick within %0d cycles, want one", bound);
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (2) clk_step;
        i_reset = 1'b0;
        checks++;
        if ({o_ms, o_sec, o_min, o_running, o_lap_active, o_tick, o_wrap} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0d:%0d.%0d run=%0b lap=%0b tick=%0b wrap=%0b, want all 0",
                     o_min, o_sec, o_ms, o_running, o_lap_active, o_tick, o_wrap);
        end
    endtask

    task automatic test_first_ticks;
        push(0, 0, 1, 0);
        push(0, 0, 2, 0);
        push(0, 0, 3, 0);
        strobe(1, 0, 0);
        checks++;
        if (o_running !== 1'b1 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL start_running: got run=%0b tick=%0b, want 1 0", o_running, o_tick);
        end
        for (int i = 1; i <= 12; i++) begin
            clk_step;
            checks++;
            if (o_tick !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL tick_period: cycle %0d got tick=%0b, want %0b", i, o_tick, (i % 4 == 0));
            end
        end
        checks++;
        if (o_ms !== 10'd3) begin
            errors++;
            $display("FAIL first_ms: got %0d, want 3", o_ms);
        end
    endtask

    task automatic test_pause_resume;
        clk_step;
        strobe(1, 0, 0);
        checks++;
        if (o_running !== 1'b0) begin
            errors++;
            $display("FAIL pause_running: got %0b, want 0", o_running);
        end
        for (int i = 0; i < 20; i++) begin
            clk_step;
            checks++;
            if (o_ms !== 10'd3 || o_tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_frozen: cycle %0d got ms=%0d tick=%0b, want 3 0", i, o_ms, o_tick);
            end
        end
        push(0, 0, 4, 0);
        strobe(1, 0, 0);
        checks++;
        if (o_running !== 1'b1 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_edge: got run=%0b tick=%0b, want 1 0", o_running, o_tick);
        end
        clk_step;
        checks++;
        if (o_tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_plus1: got tick=%0b, want 0", o_tick);
        end
        clk_step;
        checks++;
        if (o_tick !== 1'b1 || o_ms !== 10'd4) begin
            errors++;
            $display("FAIL resume_plus2: got tick=%0b ms=%0d, want 1 4", o_tick, o_ms);
        end
    endtask

    task automatic test_lap;
        push(0, 0, 5, 0);
        repeat (4) clk_step;
        checks++;
        if (o_ms !== 10'd5 || o_tick !== 1'b1) begin
            errors++;
            $display("FAIL lap_pre: got ms=%0d tick=%0b, want 5 1", o_ms, o_tick);
        end
        strobe(0, 1, 0);
        checks++;
        if (o_lap_active !== 1'b1 || o_running !== 1'b1 || o_ms !== 10'd5) begin
            errors++;
            $display("FAIL lap_enter: got lap=%0b run=%0b ms=%0d, want 1 1 5", o_lap_active, o_running, o_ms);
        end
        repeat (4) push(0, 0, 5, 0);
        for (int i = 1; i <= 15; i++) begin
            clk_step;
            checks++;
            if (o_ms !== 10'd5 || o_lap_active !== 1'b1) begin
                errors++;
                $display("FAIL lap_hold: cycle %0d got ms=%0d lap=%0b, want 5 1", i, o_ms, o_lap_active);
            end
        end
        strobe(0, 1, 0);
        checks++;
        if (o_ms !== 10'd9 || o_lap_active !== 1'b0 || o_running !== 1'b1) begin
            errors++;
            $display("FAIL lap_release: got ms=%0d lap=%0b run=%0b, want 9 0 1", o_ms, o_lap_active, o_running);
        end
    endtask

    // Running to 1:59.999 would take ~480k cycles, so the time is deposited while paused.
    task automatic test_carry_wrap;
        strobe(1, 0, 0);
        force dut.r_min = 7'd0;
        force dut.r_sec = 6'd59;
        force dut.r_ms  = 10'd998;
        repeat (2) clk_step;
        release dut.r_min;
        release dut.r_sec;
        release dut.r_ms;
        clk_step;
        checks++;
        if ({o_min, o_sec, o_ms} !== {7'd0, 6'd59, 10'd998} || o_running !== 1'b0) begin
            errors++;
            $display("FAIL preload_a: got %0d:%0d.%0d run=%0b, want 0:59.998 0", o_min, o_sec, o_ms, o_running);
        end
        push(0, 59, 999, 0);
        push(1, 0, 0, 0);
        strobe(1, 0, 0);
        wait_tick(8);
        wait_tick(8);
        checks++;
        if ({o_min, o_sec, o_ms} !== {7'd1, 6'd0, 10'd0}) begin
            errors++;
            $display("FAIL carry_min: got %0d:%0d.%0d, want 1:0.0", o_min, o_sec, o_ms);
        end

        strobe(1, 0, 0);
        force dut.r_min = 7'd1;
        force dut.r_sec = 6'd59;
        force dut.r_ms  = 10'd998;
        repeat (2) clk_step;
        release dut.r_min;
        release dut.r_sec;
        release dut.r_ms;
        clk_step;
        push(1, 59, 999, 0);
        push(0, 0, 0, 1);
        strobe(1, 0, 0);
        wait_tick(8);
        checks++;
        if (o_wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_early: got %0b, want 0", o_wrap);
        end
        wait_tick(8);
        checks++;
        if (o_wrap !== 1'b1 || {o_min, o_sec, o_ms} !== 23'd0) begin
            errors++;
            $display("FAIL wrap: got wrap=%0b %0d:%0d.%0d, want 1 0:0.0", o_wrap, o_min, o_sec, o_ms);
        end
        clk_step;
        checks++;
        if (o_wrap !== 1'b0 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL wrap_width: got wrap=%0b tick=%0b, want 0 0", o_wrap, o_tick);
        end
    endtask

    task automatic test_clear_priority;
        push(0, 0, 1, 0);
        wait_tick(8);
        strobe(0, 0, 1);
        checks++;
        if (o_running !== 1'b1 || o_ms !== 10'd1 || o_lap_active !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_run: got run=%0b ms=%0d lap=%0b, want 1 1 0", o_running, o_ms, o_lap_active);
        end
        strobe(1, 1, 0);
        checks++;
        if (o_running !== 1'b0 || o_lap_active !== 1'b0 || o_ms !== 10'd1) begin
            errors++;
            $display("FAIL ss_over_lap: got run=%0b lap=%0b ms=%0d, want 0 0 1", o_running, o_lap_active, o_ms);
        end
        strobe(0, 1, 0);
        checks++;
        if (o_lap_active !== 1'b0 || o_running !== 1'b0) begin
            errors++;
            $display("FAIL lap_in_pause: got lap=%0b run=%0b, want 0 0", o_lap_active, o_running);
        end
        strobe(1, 0, 1);
        checks++;
        if (o_running !== 1'b0 || {o_min, o_sec, o_ms} !== 23'd0) begin
            errors++;
            $display("FAIL clear_over_ss: got run=%0b %0d:%0d.%0d, want 0 0:0.0", o_running, o_min, o_sec, o_ms);
        end
        strobe(0, 1, 1);
        checks++;
        if (o_lap_active !== 1'b0 || o_running !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: got lap=%0b run=%0b, want 0 0", o_lap_active, o_running);
        end
    endtask

    task automatic test_mid_reset;
        push(0, 0, 1, 0);
        strobe(1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            clk_step;
            checks++;
            if (o_tick !== (i == 4)) begin
                errors++;
                $display("FAIL restart_period: cycle %0d got tick=%0b, want %0b", i, o_tick, (i == 4));
            end
        end
        strobe(0, 1, 0);
        checks++;
        if (o_lap_active !== 1'b1 || o_ms !== 10'd1) begin
            errors++;
            $display("FAIL lap2_enter: got lap=%0b ms=%0d, want 1 1", o_lap_active, o_ms);
        end
        push(0, 0, 1, 0);
        repeat (3) clk_step;
        checks++;
        if (o_tick !== 1'b1 || o_ms !== 10'd1) begin
            errors++;
            $display("FAIL lap2_tick: got tick=%0b ms=%0d, want 1 1", o_tick, o_ms);
        end
        repeat (3) clk_step;
        i_reset = 1'b1;
        clk_step;
        i_reset = 1'b0;
        checks++;
        if ({o_ms, o_sec, o_min, o_running, o_lap_active, o_tick, o_wrap} !== 29'd0) begin
            errors++;
            $display("FAIL mid_reset: got %0d:%0d.%0d run=%0b lap=%0b tick=%0b wrap=%0b, want all 0",
                     o_min, o_sec, o_ms, o_running, o_lap_active, o_tick, o_wrap);
        end
        repeat (5) clk_step;
        checks++;
        if (o_tick !== 1'b0 || o_running !== 1'b0 || o_ms !== 10'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got tick=%0b run=%0b ms=%0d, want 0 0 0", o_tick, o_running, o_ms);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_first_ticks;
        test_pause_resume;
        test_lap;
        test_carry_wrap;
        test_clear_priority;
        test_mid_reset;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected ticks never seen, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
